cu_sequencer: RTL and testbench

//   Control unit for the 16-bit accumulator CPU. A Moore FSM that drives the

---
 rtl/cu_sequencer_if.sv | 26 ++
 rtl/cu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cu_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cu_sequencer_if.sv
// rtl/cu_sequencer_if.sv - handshake/bus bundle between the control unit and the datapath
interface cu_sequencer_if #(
    parameter int CTRL_W = 16,
    parameter int OPC_W  = 8,
    parameter int CNT_W  = 16
);
    logic              i_start;
    logic [OPC_W-1:0]  i_opcode;
    logic              i_acc_neg;
    logic [CTRL_W-1:0] o_ctrl;
    logic              o_halt;
    logic [2:0]        o_state;
    logic [CNT_W-1:0]  o_instr_cnt;

    // Datapath / test side: drives run enable, opcode and sign flag
    modport master (
        output i_start, i_opcode, i_acc_neg,
        input  o_ctrl, o_halt, o_state, o_instr_cnt
    );

    // Control unit side
    modport slave (
        input  i_start, i_opcode, i_acc_neg,
        output o_ctrl, o_halt, o_state, o_instr_cnt
    );
endinterface

// File: rtl/cu_sequencer.sv
// rtl/cu_sequencer.sv - Moore FSM sequencing fetch/decode/execute control words
module cu_sequencer #(
    parameter int CTRL_W = 16,
    parameter int OPC_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cu_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_E1   = 4'd5,
        S_E2   = 4'd6,
        S_E3   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    localparam logic [OPC_W-1:0] OP_STORE = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_LOAD  = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_JGEZ  = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(8'h07);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(8'h0A);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(8'h0B);
    localparam logic [OPC_W-1:0] OP_NOT   = OPC_W'(8'h0C);
    localparam logic [OPC_W-1:0] OP_SHR   = OPC_W'(8'h0D);
    localparam logic [OPC_W-1:0] OP_SHL   = OPC_W'(8'h0E);

    state_t            state_q, state_d;
    logic [OPC_W-1:0]  op_q, op_d;
    logic              sub_q, sub_d;     // second pass through E3 (ALU write-back)
    logic              neg_q, neg_d;     // ACC sign captured for JGEZ
    logic              halt_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       ctrl_c;
    logic [CTRL_W-1:0] ctrl_w;

    // Memory-operand instructions: fetch operand address in E1
    function automatic logic is_mem(input logic [OPC_W-1:0] op);
        return (op == OP_STORE) || (op == OP_LOAD) || (op == OP_ADD) ||
               (op == OP_SUB)   || (op == OP_AND)  || (op == OP_OR);
    endfunction

    // Accumulator-only ALU instructions: single execute cycle
    function automatic logic is_unary(input logic [OPC_W-1:0] op);
        return (op == OP_NOT) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

    function automatic logic is_known(input logic [OPC_W-1:0] op);
        return is_mem(op) || is_unary(op) || (op == OP_JGEZ) ||
               (op == OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic logic [2:0] alu_op(input logic [OPC_W-1:0] op);
        logic [2:0] r;
        r = 3'b000;
        case (op)
            OP_ADD:  r = 3'b001;
            OP_SUB:  r = 3'b010;
            OP_AND:  r = 3'b011;
            OP_OR:   r = 3'b100;
            OP_NOT:  r = 3'b101;
            OP_SHR:  r = 3'b110;
            OP_SHL:  r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Next-state logic; retiring instructions bump the counter and pick F1 or IDLE
    always_comb begin
        logic retire;
        state_d = state_q;
        op_d    = op_q;
        sub_d   = sub_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: if (bus.i_start) state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_F3;
            S_F3:   state_d = S_DEC;
            S_DEC: begin
                op_d  = bus.i_opcode;
                neg_d = bus.i_acc_neg;
                sub_d = 1'b0;
                if (bus.i_opcode == OP_HALT)
                    state_d = S_HALT;
                else if (!is_known(bus.i_opcode))
                    retire = 1'b1;
                else
                    state_d = S_E1;
            end
            S_E1: begin
                if (is_mem(op_q))
                    state_d = S_E2;
                else
                    retire = 1'b1;
            end
            S_E2:   state_d = S_E3;
            S_E3: begin
                if (op_q == OP_STORE || sub_q) begin
                    sub_d  = 1'b0;
                    retire = 1'b1;
                end else begin
                    sub_d = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = bus.i_start ? S_F1 : S_IDLE;
        end
    end

    // State and status registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            sub_q   <= 1'b0;
            neg_q   <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
            neg_q   <= neg_d;
            halt_q  <= (state_d == S_HALT);
            cnt_q   <= cnt_d;
        end
    end

    // Control word decoded from registered state only, so inputs never reach o_ctrl
    always_comb begin
        ctrl_c = '0;
        case (state_q)
            S_F1:  ctrl_c[2] = 1'b1;
            S_F2: begin
                ctrl_c[3] = 1'b1;
                ctrl_c[0] = 1'b1;
            end
            S_F3:  ctrl_c[4]  = 1'b1;
            S_DEC: ctrl_c[14] = 1'b1;
            S_E1: begin
                if (is_mem(op_q)) begin
                    ctrl_c[15] = 1'b1;
                    ctrl_c[5]  = 1'b1;
                end else if (op_q == OP_JMP || (op_q == OP_JGEZ && !neg_q)) begin
                    ctrl_c[15] = 1'b1;
                    ctrl_c[1]  = 1'b1;
                end else if (is_unary(op_q)) begin
                    ctrl_c[9]     = 1'b1;
                    ctrl_c[13:11] = alu_op(op_q);
                end
            end
            S_E2: begin
                if (op_q == OP_STORE) ctrl_c[7] = 1'b1;
                else                  ctrl_c[3] = 1'b1;
            end
            S_E3: begin
                if (op_q == OP_STORE) begin
                    ctrl_c[6] = 1'b1;
                end else if (!sub_q) begin
                    ctrl_c[8] = 1'b1;
                end else begin
                    ctrl_c[9]     = 1'b1;
                    ctrl_c[13:11] = alu_op(op_q);
                end
            end
            default: ctrl_c = '0;
        endcase
    end

    // Reserved upper control bits stay zero
    always_comb begin
        ctrl_w       = '0;
        ctrl_w[15:0] = ctrl_c;
    end

    assign bus.o_ctrl      = ctrl_w;
    assign bus.o_halt      = halt_q;
    assign bus.o_state     = (state_q == S_HALT) ? 3'd0 : state_q[2:0];
    assign bus.o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// tb/tb_cu_sequencer.sv - table-driven and scoreboard bench for cu_sequencer
module tb_cu_sequencer;

    localparam int CW = 8;

    logic clk;
    logic rst_n;

    cu_sequencer_if #(.CTRL_W(16), .OPC_W(8), .CNT_W(CW)) bus ();

    cu_sequencer #(.CTRL_W(16), .OPC_W(8), .CNT_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0]   exp_q[$];
    logic [CW-1:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: one expected control word per negedge while the queue holds any
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("ctrl", {16'h0, bus.o_ctrl}, {16'h0, e});
        end
    end

    task automatic drain(input string name);
        for (int c = 0; c < 80 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check({name, "_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic push_fetch();
        exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0009);
        exp_q.push_back(16'h0010);
        exp_q.push_back(16'h4000);
    endtask

    typedef struct {
        logic [7:0]  opc;
        logic        neg;
        int          n;
        logic [63:0] ex;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{8'h02, 1'b0, 4, {16'h0200, 16'h0100, 16'h0008, 16'h8020}};
        vecs[1]  = '{8'h03, 1'b0, 4, {16'h0A00, 16'h0100, 16'h0008, 16'h8020}};
        vecs[2]  = '{8'h04, 1'b1, 4, {16'h1200, 16'h0100, 16'h0008, 16'h8020}};
        vecs[3]  = '{8'h0A, 1'b0, 4, {16'h1A00, 16'h0100, 16'h0008, 16'h8020}};
        vecs[4]  = '{8'h0B, 1'b0, 4, {16'h2200, 16'h0100, 16'h0008, 16'h8020}};
        vecs[5]  = '{8'h01, 1'b0, 3, {16'h0000, 16'h0040, 16'h0080, 16'h8020}};
        vecs[6]  = '{8'h06, 1'b1, 1, {48'h0, 16'h8002}};
        vecs[7]  = '{8'h05, 1'b1, 1, {48'h0, 16'h0000}};
        vecs[8]  = '{8'h05, 1'b0, 1, {48'h0, 16'h8002}};
        vecs[9]  = '{8'h0C, 1'b0, 1, {48'h0, 16'h2A00}};
        vecs[10] = '{8'h0D, 1'b0, 1, {48'h0, 16'h3200}};
        vecs[11] = '{8'h0E, 1'b0, 1, {48'h0, 16'h3A00}};
        vecs[12] = '{8'h00, 1'b0, 0, 64'h0};
        vecs[13] = '{8'h3F, 1'b0, 0, 64'h0};
        vecs[14] = '{8'hFF, 1'b1, 0, 64'h0};

        rst_n         = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_opcode  = 8'h00;
        bus.i_acc_neg = 1'b0;
        exp_cnt       = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, and nothing pulses while i_start is low
        @(negedge clk);
        check("rst_state", {29'h0, bus.o_state}, 0);
        check("rst_halt", {31'h0, bus.o_halt}, 0);
        check("rst_cnt", {24'h0, bus.o_instr_cnt}, 0);
        for (int i = 0; i < 5; i++) exp_q.push_back(16'h0000);
        drain("idle");

        // Reset asserted in E2 of STORE clears everything immediately
        @(posedge clk) #1;
        bus.i_opcode = 8'h01;
        bus.i_start  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("store_e2_ctrl", {16'h0, bus.o_ctrl}, 32'h0080);
        check("store_e2_state", {29'h0, bus.o_state}, 6);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {16'h0, bus.o_ctrl}, 0);
        check("mid_rst_state", {29'h0, bus.o_state}, 0);
        check("mid_rst_cnt", {24'h0, bus.o_instr_cnt}, 0);
        bus.i_start = 1'b0;
        @(posedge clk) #1 rst_n = 1'b1;
        exp_cnt = '0;

        // Table of single instructions, start dropped during F1
        for (int v = 0; v < 15; v++) begin
            @(posedge clk) #1;
            bus.i_opcode  = vecs[v].opc;
            bus.i_acc_neg = vecs[v].neg;
            bus.i_start   = 1'b1;
            exp_q.push_back(16'h0000);
            push_fetch();
            for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].ex[16*k +: 16]);
            exp_q.push_back(16'h0000);
            @(posedge clk) #1 bus.i_start = 1'b0;
            drain("vec");
            exp_cnt = exp_cnt + 1'b1;
            check("vec_cnt", {24'h0, bus.o_instr_cnt}, {24'h0, exp_cnt});
            check("vec_state", {29'h0, bus.o_state}, 0);
        end

        // i_start dropped during F2 of ADD: ADD still completes, then IDLE
        @(posedge clk) #1;
        bus.i_opcode = 8'h03;
        bus.i_start  = 1'b1;
        exp_q.push_back(16'h0000);
        push_fetch();
        exp_q.push_back(16'h8020);
        exp_q.push_back(16'h0008);
        exp_q.push_back(16'h0100);
        exp_q.push_back(16'h0A00);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        repeat (2) @(posedge clk);
        #1 bus.i_start = 1'b0;
        drain("add_drop");
        exp_cnt = exp_cnt + 1'b1;
        check("add_drop_cnt", {24'h0, bus.o_instr_cnt}, {24'h0, exp_cnt});

        // Back-to-back NOP 3F: F1 directly follows DEC while i_start stays high
        @(posedge clk) #1;
        bus.i_opcode = 8'h3F;
        bus.i_start  = 1'b1;
        exp_q.push_back(16'h0000);
        push_fetch();
        push_fetch();
        exp_q.push_back(16'h0000);
        repeat (6) @(posedge clk);
        #1 bus.i_start = 1'b0;
        drain("nop_b2b");
        exp_cnt = exp_cnt + 2'd2;
        check("nop_b2b_cnt", {24'h0, bus.o_instr_cnt}, {24'h0, exp_cnt});

        // Counter wrap: NOPs up to all-ones, then one more wraps to zero
        bus.i_opcode = 8'h00;
        while (exp_cnt != {CW{1'b1}}) begin
            @(posedge clk) #1 bus.i_start = 1'b1;
            @(posedge clk) #1 bus.i_start = 1'b0;
            repeat (4) @(posedge clk);
            exp_cnt = exp_cnt + 1'b1;
        end
        #1;
        check("cnt_full", {24'h0, bus.o_instr_cnt}, {24'h0, {CW{1'b1}}});
        @(posedge clk) #1 bus.i_start = 1'b1;
        @(posedge clk) #1 bus.i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("cnt_wrap", {24'h0, bus.o_instr_cnt}, 0);
        exp_cnt = '0;

        // HALT: control stays zero with i_start high, count frozen
        @(posedge clk) #1;
        bus.i_opcode = 8'h07;
        bus.i_start  = 1'b1;
        exp_q.push_back(16'h0000);
        push_fetch();
        for (int i = 0; i < 20; i++) exp_q.push_back(16'h0000);
        drain("halt");
        check("halt_flag", {31'h0, bus.o_halt}, 1);
        check("halt_state", {29'h0, bus.o_state}, 0);
        check("halt_cnt", {24'h0, bus.o_instr_cnt}, {24'h0, exp_cnt});

        // Only reset leaves HALT
        #1 rst_n = 1'b0;
        #1;
        check("halt_rst", {31'h0, bus.o_halt}, 0);
        bus.i_start = 1'b0;
        @(posedge clk) #1 rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
